// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv front end and decode.
// Contents: default pc width, instruction length, the fetch entry layout
// handed from fetch to decode, and the base opcode map.
package riscv_pkg;

    localparam int unsigned PC_SIZE_DEFAULT = 32;
    localparam int unsigned ILEN            = 32;

    // One prefetched instruction as seen by decode.
    typedef struct packed {
        logic [PC_SIZE_DEFAULT-1:0] pc;
        logic [ILEN-1:0]            instr;
        logic                       err;
    } fetch_entry_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // True for opcodes that may redirect the fetch stream.
    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with registered head and synchronous flush.
// Ports: clk/rstf (async active-low reset), flush_i (drop all entries),
// push_i/wdata_i, pop_i, rdata_o (head entry), empty_o, full_o, count_o.
// Push and pop together when full is legal; push when full without pop is not.
module riscv_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rstf,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    // Explicit wrap so non power-of-two depths work.
    function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
        return (p == AddrW'(Depth - 1)) ? '0 : p + AddrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!rstf)
        !(push_i && !pop_i && full_o && !flush_i));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: issues word-aligned iBus requests with up to
// MAX_OUTSTANDING in flight, buffers responses in a prefetch FIFO for decode,
// squashes in-flight responses on redirect and halts after a bus error.
// Ports: clk/rstf; iBus_cmd_* request channel; iBus_rsp_* in-order response;
// fetch_* decode handshake (registered head); redirect_valid/pc; busy.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned        PC_SIZE         = PC_SIZE_DEFAULT,
    parameter logic [PC_SIZE-1:0] RESET_PC        = '0,
    parameter int unsigned        FIFO_DEPTH      = 4,
    parameter int unsigned        MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rstf,
    output logic               iBus_cmd_valid,
    input  logic               iBus_cmd_ready,
    output logic [PC_SIZE-1:0] iBus_cmd_payload_pc,
    input  logic               iBus_rsp_ready,
    input  logic               iBus_rsp_err,
    input  logic [ILEN-1:0]    iBus_rsp_instr,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [PC_SIZE-1:0] fetch_pc,
    output logic [ILEN-1:0]    fetch_instr,
    output logic               fetch_err,
    input  logic               redirect_valid,
    input  logic [PC_SIZE-1:0] redirect_pc,
    output logic               busy
);

    localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

    // Same layout as fetch_entry_t, sized by this instance's PC_SIZE.
    typedef struct packed {
        logic [PC_SIZE-1:0] pc;
        logic [ILEN-1:0]    instr;
        logic               err;
    } entry_t;

    logic [PC_SIZE-1:0]  next_pc_q, next_pc_d;
    logic [OutW-1:0]     outstanding_q, outstanding_d;
    logic [OutW-1:0]     drop_cnt_q, drop_cnt_d;
    logic                halted_q, halted_d;
    logic                cmd_accept, rsp_drop, fifo_push, fifo_pop;
    logic [31:0]         occupancy;
    entry_t              push_entry, head_entry;
    logic                fifo_empty, fifo_full;
    logic [FifoCntW-1:0] fifo_count;
    logic [PC_SIZE-1:0]  rsp_pc;
    logic                pcq_empty, pcq_full;
    logic [OutW-1:0]     pcq_count;
    logic                unused_status;

    always_comb begin
        // Slots already claimed: buffered entries plus responses that will be kept.
        occupancy      = 32'(fifo_count) + 32'(outstanding_q) - 32'(drop_cnt_q);
        // rstf gate keeps the request channel quiet while reset is held.
        iBus_cmd_valid = rstf & ~redirect_valid & ~halted_q
                         & (32'(outstanding_q) < MAX_OUTSTANDING)
                         & (occupancy < FIFO_DEPTH);
        cmd_accept     = iBus_cmd_valid & iBus_cmd_ready;
        rsp_drop       = iBus_rsp_ready & (drop_cnt_q != '0);
        fifo_push      = iBus_rsp_ready & ~rsp_drop & ~redirect_valid;
        fifo_pop       = fetch_valid & fetch_ready & ~redirect_valid;

        outstanding_d  = outstanding_q + OutW'(cmd_accept) - OutW'(iBus_rsp_ready);
        next_pc_d      = next_pc_q;
        drop_cnt_d     = drop_cnt_q - OutW'(rsp_drop);
        halted_d       = halted_q;

        if (cmd_accept) next_pc_d = next_pc_q + PC_SIZE'(4);
        if (fifo_push && iBus_rsp_err) halted_d = 1'b1;

        if (redirect_valid) begin
            next_pc_d  = {redirect_pc[PC_SIZE-1:2], 2'b00};
            // Post-response count, so a response arriving now is squashed too.
            drop_cnt_d = outstanding_d;
            halted_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            next_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            next_pc_q     <= next_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            halted_q      <= halted_d;
        end
    end

    assign push_entry = '{pc: rsp_pc, instr: iBus_rsp_instr, err: iBus_rsp_err};

    riscv_sync_fifo #(
        .Width ($bits(entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_prefetch_fifo (
        .clk     (clk),
        .rstf    (rstf),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Pcs of in-flight requests; never flushed since squashed responses still pop it.
    riscv_sync_fifo #(
        .Width (PC_SIZE),
        .Depth (MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk     (clk),
        .rstf    (rstf),
        .flush_i (1'b0),
        .push_i  (cmd_accept),
        .wdata_i (next_pc_q),
        .pop_i   (iBus_rsp_ready),
        .rdata_o (rsp_pc),
        .empty_o (pcq_empty),
        .full_o  (pcq_full),
        .count_o (pcq_count)
    );

    assign unused_status       = ^{fifo_full, pcq_empty, pcq_full, pcq_count};

    assign iBus_cmd_payload_pc = next_pc_q;
    assign fetch_valid         = ~fifo_empty;
    assign fetch_pc            = head_entry.pc;
    assign fetch_instr         = head_entry.instr;
    assign fetch_err           = head_entry.err;
    assign busy                = (outstanding_q != '0) | (drop_cnt_q != '0);

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;

    localparam int unsigned MaxOut = 2;

    logic        clk = 1'b0;
    logic        rstf = 1'b0;
    logic        iBus_cmd_valid, iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready, iBus_rsp_err;
    logic [31:0] iBus_rsp_instr;
    logic        fetch_valid, fetch_ready, fetch_err;
    logic [31:0] fetch_pc, fetch_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    riscv_fetch_unit dut (
        .clk                 (clk),
        .rstf                (rstf),
        .iBus_cmd_valid      (iBus_cmd_valid),
        .iBus_cmd_ready      (iBus_cmd_ready),
        .iBus_cmd_payload_pc (iBus_cmd_payload_pc),
        .iBus_rsp_ready      (iBus_rsp_ready),
        .iBus_rsp_err        (iBus_rsp_err),
        .iBus_rsp_instr      (iBus_rsp_instr),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_pc            (fetch_pc),
        .fetch_instr         (fetch_instr),
        .fetch_err           (fetch_err),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;

    // Bus model: accepted request pcs and the cycle each was accepted.
    logic [31:0] bus_pc[$];
    int unsigned bus_t[$];
    logic        err_en = 1'b0;
    logic [31:0] err_pc = '0;
    logic        err_rand = 1'b0;

    // Values sampled in the most recent step.
    logic        s_cv, s_fv, s_ferr, s_busy, s_rsp, s_acc, s_pop;
    logic [31:0] s_cpc, s_fpc, s_finstr;
    int unsigned s_out;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hA5C3, ~pc[17:2]};
    endfunction

    function automatic logic is_err(input logic [31:0] pc);
        return (err_en && pc == err_pc) || (err_rand && pc[6:2] == 5'd13);
    endfunction

    // One clock cycle: drive inputs, sample outputs, advance the bus model.
    task automatic step(input logic cr, input logic ren, input logic fr,
                        input logic rv, input logic [31:0] rpc);
        iBus_cmd_ready = cr;
        fetch_ready    = fr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (ren && bus_pc.size() != 0 && bus_t[0] < cyc) begin
            iBus_rsp_ready = 1'b1;
            iBus_rsp_instr = mk_instr(bus_pc[0]);
            iBus_rsp_err   = is_err(bus_pc[0]);
        end else begin
            iBus_rsp_ready = 1'b0;
            iBus_rsp_instr = $urandom;
            iBus_rsp_err   = 1'($urandom_range(0, 1));
        end
        #1;
        s_cv = iBus_cmd_valid;  s_cpc = iBus_cmd_payload_pc;
        s_fv = fetch_valid;     s_fpc = fetch_pc;  s_finstr = fetch_instr;
        s_ferr = fetch_err;     s_busy = busy;     s_rsp = iBus_rsp_ready;
        s_out = bus_pc.size();
        s_acc = s_cv & cr;
        s_pop = s_fv & fr & ~rv;
        @(posedge clk);
        if (s_rsp) begin
            void'(bus_pc.pop_front());
            void'(bus_t.pop_front());
        end
        if (s_acc) begin
            bus_pc.push_back(s_cpc);
            bus_t.push_back(cyc);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rstf = 1'b0;
        iBus_cmd_ready = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; iBus_rsp_ready = 1'b0; iBus_rsp_err = 1'b0; iBus_rsp_instr = '0;
        bus_pc.delete(); bus_t.delete();
        err_en = 1'b0; err_rand = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rstf = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rstf = 1'b0;
        #1;
        n_vec++; if (iBus_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid got=%b want=0", iBus_cmd_valid); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_valid got=%b want=0", fetch_valid); end
        n_vec++; if (fetch_pc !== 32'h0) begin n_bad++; $display("FAIL reset_fetch_pc got=%h want=0", fetch_pc); end
        n_vec++; if (fetch_instr !== 32'h0) begin n_bad++; $display("FAIL reset_fetch_instr got=%h want=0", fetch_instr); end
        n_vec++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_err got=%b want=0", fetch_err); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rstf = 1'b1;
        // Reset again in the middle of traffic.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        rstf = 1'b0;
        #1;
        n_vec++; if (iBus_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_cmd_valid got=%b want=0", iBus_cmd_valid); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_fetch_valid got=%b want=0", fetch_valid); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        n_vec++; if (fetch_pc !== 32'h0) begin n_bad++; $display("FAIL midreset_fetch_pc got=%h want=0", fetch_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, '0);
            n_vec++; if (s_cv !== 1'b1 || s_cpc !== 32'(4 * k)) begin n_bad++; $display("FAIL stream_cmd k=%0d got=%b/%h want=1/%h", k, s_cv, s_cpc, 32'(4 * k)); end
            if (k >= 2) begin
                want = 32'(4 * (k - 2));
                n_vec++; if (s_fv !== 1'b1 || s_fpc !== want || s_finstr !== mk_instr(want) || s_ferr !== 1'b0) begin
                    n_bad++; $display("FAIL stream_fetch k=%0d got=%b/%h/%h/%b want=1/%h/%h/0", k, s_fv, s_fpc, s_finstr, s_ferr, want, mk_instr(want));
                end
            end else begin
                n_vec++; if (s_fv !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid k=%0d got=%b want=0", k, s_fv); end
            end
        end
    endtask

    task automatic test_backpressure();
        int unsigned n_acc;
        logic [31:0] got[$];
        logic [31:0] first_cmd;
        logic        have_cmd;
        do_reset();
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0);
            if (s_acc) n_acc++;
        end
        n_vec++; if (n_acc != 4) begin n_bad++; $display("FAIL bp_requests got=%0d want=4", n_acc); end
        n_vec++; if (s_cv !== 1'b0) begin n_bad++; $display("FAIL bp_cmd_stopped got=%b want=0", s_cv); end
        n_vec++; if (s_fv !== 1'b1 || s_fpc !== 32'h0) begin n_bad++; $display("FAIL bp_head got=%b/%h want=1/0", s_fv, s_fpc); end
        have_cmd = 1'b0; first_cmd = '0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, '0);
            if (s_pop) got.push_back(s_fpc);
            if (s_acc && !have_cmd) begin have_cmd = 1'b1; first_cmd = s_cpc; end
        end
        n_vec++; if (!have_cmd || first_cmd !== 32'h10) begin n_bad++; $display("FAIL bp_resume_pc got=%b/%h want=1/10", have_cmd, first_cmd); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (got.size() <= i) begin n_bad++; $display("FAIL bp_drain i=%0d got=none want=%h", i, 32'(4 * i)); end
            else if (got[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_drain i=%0d got=%h want=%h", i, got[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        n_vec++; if (s_acc !== 1'b1 || s_cpc !== 32'h20) begin n_bad++; $display("FAIL rd_cmd0 got=%b/%h want=1/20", s_acc, s_cpc); end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        n_vec++; if (s_acc !== 1'b1 || s_cpc !== 32'h24) begin n_bad++; $display("FAIL rd_cmd1 got=%b/%h want=1/24", s_acc, s_cpc); end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        n_vec++; if (s_cv !== 1'b0) begin n_bad++; $display("FAIL rd_max_outstanding got=%b want=0", s_cv); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
        n_vec++; if (s_cv !== 1'b0 || s_busy !== 1'b1) begin n_bad++; $display("FAIL rd_redirect_cycle got=%b/%b want=0/1", s_cv, s_busy); end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_vec++; if (s_busy !== 1'b1 || s_fv !== 1'b0) begin n_bad++; $display("FAIL rd_drop0 got=%b/%b want=1/0", s_busy, s_fv); end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        n_vec++; if (s_busy !== 1'b1 || s_fv !== 1'b0) begin n_bad++; $display("FAIL rd_drop1 got=%b/%b want=1/0", s_busy, s_fv); end
        n_vec++; if (s_cv !== 1'b1 || s_cpc !== 32'h100) begin n_bad++; $display("FAIL rd_new_cmd got=%b/%h want=1/100", s_cv, s_cpc); end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_busy !== 1'b0 || s_fv !== 1'b0) begin n_bad++; $display("FAIL rd_drained got=%b/%b want=0/0", s_busy, s_fv); end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_fv !== 1'b1 || s_fpc !== 32'h100 || s_finstr !== mk_instr(32'h100)) begin
            n_bad++; $display("FAIL rd_first_fetch got=%b/%h/%h want=1/100/%h", s_fv, s_fpc, s_finstr, mk_instr(32'h100));
        end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        n_vec++; if (s_cv !== 1'b0) begin n_bad++; $display("FAIL col_no_cmd got=%b want=0", s_cv); end
        n_vec++; if (s_rsp !== 1'b1 || s_fv !== 1'b1) begin n_bad++; $display("FAIL col_setup rsp/valid got=%b/%b want=1/1", s_rsp, s_fv); end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_fv !== 1'b0) begin n_bad++; $display("FAIL col_flushed got=%b want=0", s_fv); end
        n_vec++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL col_busy got=%b want=0", s_busy); end
        n_vec++; if (s_cv !== 1'b1 || s_cpc !== 32'h200) begin n_bad++; $display("FAIL col_cmd got=%b/%h want=1/200", s_cv, s_cpc); end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_fv !== 1'b1 || s_fpc !== 32'h200) begin n_bad++; $display("FAIL col_fetch got=%b/%h want=1/200", s_fv, s_fpc); end
    endtask

    task automatic test_error();
        logic [31:0] want;
        logic        seen;
        int unsigned n_del;
        do_reset();
        err_en = 1'b1; err_pc = 32'h8;
        want = '0; seen = 1'b0; n_del = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, '0);
            if (seen) begin
                n_vec++; if (s_cv !== 1'b0) begin n_bad++; $display("FAIL err_halted k=%0d got=%b want=0", k, s_cv); end
            end
            if (s_pop) begin
                n_vec++; if (s_fpc !== want || s_ferr !== (want == 32'h8)) begin
                    n_bad++; $display("FAIL err_delivery got=%h/%b want=%h/%b", s_fpc, s_ferr, want, want == 32'h8);
                end
                if (s_ferr) seen = 1'b1;
                want += 4; n_del++;
            end
        end
        n_vec++; if (n_del != 4) begin n_bad++; $display("FAIL err_count got=%0d want=4", n_del); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        n_vec++; if (s_cv !== 1'b0) begin n_bad++; $display("FAIL err_redirect_cmd got=%b want=0", s_cv); end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_cv !== 1'b1 || s_cpc !== 32'h40) begin n_bad++; $display("FAIL err_resume_cmd got=%b/%h want=1/40", s_cv, s_cpc); end
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_fv !== 1'b1 || s_fpc !== 32'h40 || s_ferr !== 1'b0) begin
            n_bad++; $display("FAIL err_resume_fetch got=%b/%h/%b want=1/40/0", s_fv, s_fpc, s_ferr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        n_vec++; if (s_acc !== 1'b1 || s_cpc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_cmd0 got=%b/%h want=1/fffffffc", s_acc, s_cpc); end
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        n_vec++; if (s_acc !== 1'b1 || s_cpc !== 32'h0) begin n_bad++; $display("FAIL wrap_cmd1 got=%b/%h want=1/0", s_acc, s_cpc); end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_fv !== 1'b1 || s_fpc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_fetch0 got=%b/%h want=1/fffffffc", s_fv, s_fpc); end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        n_vec++; if (s_fv !== 1'b1 || s_fpc !== 32'h0) begin n_bad++; $display("FAIL wrap_fetch1 got=%b/%h want=1/0", s_fv, s_fpc); end
    endtask

    // Reference: decode sees one unbroken pc+4 stream starting at the last redirect
    // target; once an error entry is consumed nothing new is requested.
    task automatic test_random();
        logic [31:0] exp_pc, exp_cmd, rpc, p_fpc, p_finstr;
        logic        cr, ren, fr, rv, saw_err, p_hold, p_ferr;
        do_reset();
        err_rand = 1'b1;
        exp_pc = '0; exp_cmd = '0; saw_err = 1'b0; p_hold = 1'b0;
        p_fpc = '0; p_finstr = '0; p_ferr = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            cr  = ($urandom_range(0, 3) != 0);
            ren = ($urandom_range(0, 2) != 0);
            fr  = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 39) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                              : ($urandom & 32'h3FF);
            step(cr, ren, fr, rv, rpc);
            n_vec++; if (s_busy !== (s_out != 0)) begin n_bad++; $display("FAIL rnd_busy k=%0d got=%b want=%b", k, s_busy, s_out != 0); end
            n_vec++; if (s_out > MaxOut) begin n_bad++; $display("FAIL rnd_outstanding k=%0d got=%0d want<=%0d", k, s_out, MaxOut); end
            if (rv || saw_err) begin
                n_vec++; if (s_cv !== 1'b0) begin n_bad++; $display("FAIL rnd_cmd_blocked k=%0d got=%b want=0", k, s_cv); end
            end
            if (s_acc) begin
                n_vec++; if (s_cpc !== exp_cmd) begin n_bad++; $display("FAIL rnd_cmd_pc k=%0d got=%h want=%h", k, s_cpc, exp_cmd); end
                exp_cmd += 4;
            end
            if (p_hold) begin
                n_vec++; if (s_fv !== 1'b1 || s_fpc !== p_fpc || s_finstr !== p_finstr || s_ferr !== p_ferr) begin
                    n_bad++; $display("FAIL rnd_hold k=%0d got=%b/%h/%h/%b want=1/%h/%h/%b", k, s_fv, s_fpc, s_finstr, s_ferr, p_fpc, p_finstr, p_ferr);
                end
            end
            if (s_pop) begin
                n_vec++; if (s_fpc !== exp_pc || s_finstr !== mk_instr(exp_pc) || s_ferr !== is_err(exp_pc)) begin
                    n_bad++; $display("FAIL rnd_fetch k=%0d got=%h/%h/%b want=%h/%h/%b", k, s_fpc, s_finstr, s_ferr, exp_pc, mk_instr(exp_pc), is_err(exp_pc));
                end
                if (is_err(exp_pc)) saw_err = 1'b1;
                exp_pc += 4;
            end
            if (rv) begin
                exp_pc = {rpc[31:2], 2'b00}; exp_cmd = {rpc[31:2], 2'b00}; saw_err = 1'b0;
            end
            p_hold = s_fv & ~fr & ~rv;
            p_fpc = s_fpc; p_finstr = s_finstr; p_ferr = s_ferr;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collision();
        test_error();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the riscv core. It decouples the iBus from decode with a prefetch FIFO and allows multiple outstanding iBus requests. It supports branch/jump redirect with a flush that squashes in-flight responses, and it tags bus errors on the instruction they belong to. It sits between the iBus and the decode stage and replaces the ad-hoc pc/instr_buf/branch_taken_1d logic.

Parameters:
PC_SIZE, 32, width of pc and redirect address
RESET_PC, 32'h0, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries (power of 2, >=2)
MAX_OUTSTANDING, 2, iBus requests accepted but not yet responded (>=1)

Ports:
clk  in  1  clock
rstf  in  1  asynchronous active-low reset
iBus_cmd_valid  out  1  fetch request valid
iBus_cmd_ready  in  1  bus accepts request
iBus_cmd_payload_pc  out  PC_SIZE  request address, word aligned
iBus_rsp_ready  in  1  response valid this cycle (in-order, one per accepted cmd)
iBus_rsp_err  in  1  bus error for this response
iBus_rsp_instr  in  32  instruction word
fetch_valid  out  1  decode-side entry valid
fetch_ready  in  1  decode consumes entry
fetch_pc  out  PC_SIZE  pc of head entry
fetch_instr  out  32  instruction of head entry
fetch_err  out  1  head entry carries a bus error
redirect_valid  in  1  flush and restart fetch (branch taken / jump)
redirect_pc  in  PC_SIZE  restart address; bits [1:0] forced to 0
busy  out  1  outstanding requests or drops pending

Behaviour:
- Reset (async on rstf low): next_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, halted=0. Outputs: iBus_cmd_valid=0, fetch_valid=0, fetch_pc=0, fetch_instr=0, fetch_err=0, busy=0. The first request is issued in the first cycle after rstf deasserts.
- Credit: iBus_cmd_valid = ~redirect_valid & ~halted & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding - drop_cnt < FIFO_DEPTH). This guarantees that a non-dropped response always finds FIFO space. The FIFO never overflows; overflow is an assertion.
- Request accepted (valid & ready): outstanding+1, next_pc += 4 (wraps modulo 2^PC_SIZE). The pc of each request is pushed to an internal MAX_OUTSTANDING-deep pc queue. Payload is held stable while valid & ~ready.
- Response (iBus_rsp_ready): outstanding-1, pc queue pops. If drop_cnt>0, the response is discarded and drop_cnt decrements. Otherwise {pc, instr, err} is pushed to the FIFO.
- Response latency: a response in cycle N is visible on fetch_* at N+1 at the earliest. fetch_* is driven from the registered FIFO head and is stable while fetch_valid & ~fetch_ready.
- Same-cycle accept+response: both counters update net 0.
- Redirect in cycle N:
  - FIFO flushed; fetch_valid=0 at N+1.
  - No cmd issued in N.
  - next_pc = redirect_pc & ~3.
  - drop_cnt = outstanding (post-response-update value, so a response arriving in N is itself discarded).
  - halted cleared.
  - A fetch_ready pop in N is ignored.
  - Redirect has priority over every other event.
- Error: an entry with err=1 is delivered normally. When it is pushed to the FIFO, halted=1 and no further requests are issued until a redirect. Responses already in flight are still accepted.
- Simultaneous FIFO push and pop when full: legal; count is unchanged.
- busy = (outstanding != 0) | (drop_cnt != 0).
- Reset asserted mid-transaction: all state cleared immediately. The bus side must also be reset; responses to pre-reset requests are not tracked.

Decomposition:
- riscv_pkg: PC_SIZE default, typedef fetch_entry_t {pc, instr[31:0], err}, ILEN=32, and the opcode localparams shared with decode.
- One sub-module: riscv_sync_fifo (parametrised width/depth, push/pop/flush, count, async active-low reset on clk/rstf). It is instantiated twice: once as the prefetch FIFO of fetch_entry_t, once as the pc queue.

Test Plan:
- Reset release, iBus_cmd_ready=1, 1-cycle response, fetch_ready=1 -> requests at pc 0,4,8,… every cycle; fetch_pc 0 appears 2 cycles after first cmd with the matching instr; no gaps in steady state.
- fetch_ready=0 with FIFO_DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests issued, then iBus_cmd_valid=0; FIFO holds pcs 0,4,8,12. Raising fetch_ready resumes with pc 16.
- 2 requests outstanding (pc 0x20,0x24), redirect_valid with redirect_pc=0x103 -> both responses discarded, busy high until 2nd response. Next request pc=0x100; first fetch_pc=0x100.
- Redirect in the same cycle as a response and a fetch_ready pop -> response dropped, FIFO empty next cycle, no cmd that cycle, cmd at redirect pc next cycle.
- Response for pc 0x8 with iBus_rsp_err=1 -> fetch_err=1 with fetch_pc=0x8; no new cmd issued. Redirect to 0x40 -> fetching resumes at 0x40 with fetch_err=0.
- next_pc=0xFFFFFFFC accepted -> next request pc=0x0 (wrap).
